// File: rtl/parity_chk_pkg.sv
// Shared types and parameter defaults for the parity frame checker.
package parity_chk_pkg;

    typedef enum logic {
        ACCUM,
        RESULT
    } state_t;

    localparam int FRAME_LEN_DEF = 8;
    localparam int CNT_W_DEF     = 16;

endpackage

// File: rtl/parity_frame_checker_if.sv
// Beat input and result output handshakes of the parity frame checker.
interface parity_frame_checker_if;

    logic in_valid;
    logic in_ready;
    logic in_bit;
    logic in_exp;
    logic res_valid;
    logic res_ready;
    logic res_pass;
    logic res_parity;

    modport master (
        output in_valid, in_bit, in_exp, res_ready,
        input  in_ready, res_valid, res_pass, res_parity
    );

    modport slave (
        input  in_valid, in_bit, in_exp, res_ready,
        output in_ready, res_valid, res_pass, res_parity
    );

endinterface

// File: rtl/parity_frame_checker_sat_counter.sv
// Saturating up-counter with synchronous clear that takes priority over increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/parity_frame_checker.sv
// Accumulates FRAME_LEN parity beats per frame, compares against the expected
// parity, holds the result until handed off and keeps frame/error tallies.
module parity_frame_checker
    import parity_chk_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    parity_frame_checker_if.slave  bus,
    input  logic                   clr,
    output logic [CNT_W-1:0]       frame_cnt,
    output logic [CNT_W-1:0]       err_cnt
);

    localparam logic [7:0] LAST = 8'(FRAME_LEN - 1);

    state_t     state, state_nxt;
    logic       live;
    logic       acc, acc_nxt;
    logic [7:0] idx, idx_nxt;
    logic       pass_q, pass_nxt;
    logic       parity_q, parity_nxt;
    logic       in_ready;
    logic       res_valid;
    logic       hs;

    // live holds in_ready low through reset and for the edge that releases it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ACCUM;
            live     <= 1'b0;
            acc      <= 1'b0;
            idx      <= '0;
            pass_q   <= 1'b0;
            parity_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            live     <= 1'b1;
            acc      <= acc_nxt;
            idx      <= idx_nxt;
            pass_q   <= pass_nxt;
            parity_q <= parity_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        acc_nxt    = acc;
        idx_nxt    = idx;
        pass_nxt   = pass_q;
        parity_nxt = parity_q;
        in_ready   = 1'b0;
        res_valid  = 1'b0;
        hs         = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = live;
                if (live && bus.in_valid) begin
                    acc_nxt = acc ^ bus.in_bit;
                    idx_nxt = idx + 8'd1;
                    if (idx == LAST) begin
                        parity_nxt = acc ^ bus.in_bit;
                        pass_nxt   = ((acc ^ bus.in_bit) == bus.in_exp);
                        state_nxt  = RESULT;
                    end
                end
            end
            RESULT: begin
                res_valid = 1'b1;
                if (bus.res_ready) begin
                    hs        = 1'b1;
                    state_nxt = ACCUM;
                    acc_nxt   = 1'b0;
                    idx_nxt   = '0;
                end
            end
        endcase
    end

    assign bus.in_ready   = in_ready;
    assign bus.res_valid  = res_valid;
    assign bus.res_pass   = pass_q;
    assign bus.res_parity = parity_q;

    sat_counter #(.CNT_W(CNT_W)) u_frame_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hs),
        .clr   (clr),
        .cnt   (frame_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hs && !pass_q),
        .clr   (clr),
        .cnt   (err_cnt)
    );

endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed self-checking bench for parity_frame_checker (FRAME_LEN=8, CNT_W=4).
module tb_parity_frame_checker;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic [3:0] frame_cnt;
    logic [3:0] err_cnt;
    int         checks;
    int         errors;

    parity_frame_checker_if bus ();

    parity_frame_checker #(.FRAME_LEN(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .clr       (clr),
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic send_frame(input logic [7:0] bits, input logic e);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL beat_ready[%0d]: got %b expected 1", i, bus.in_ready);
            end
            checks++;
            if (bus.res_valid !== 1'b0) begin
                errors++;
                $display("FAIL early_valid[%0d]: got %b expected 0", i, bus.res_valid);
            end
            bus.in_valid = 1'b1;
            bus.in_bit   = bits[i];
            bus.in_exp   = e;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_bit   = 1'b0;
        checks++;
        if (bus.res_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency: res_valid got %b expected 1", bus.res_valid);
        end
    endtask

    task automatic clear_counters;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if (frame_cnt !== 4'd0 || err_cnt !== 4'd0) begin
            errors++;
            $display("FAIL clr: got frame %0d err %0d expected 0 0", frame_cnt, err_cnt);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.res_valid, bus.res_pass, bus.res_parity} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0000",
                     {bus.in_ready, bus.res_valid, bus.res_pass, bus.res_parity});
        end
        checks++;
        if (frame_cnt !== 4'd0 || err_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d %0d expected 0 0", frame_cnt, err_cnt);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: got %b expected 0", bus.in_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_edge: got %b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_pass;
        clear_counters();
        bus.res_ready = 1'b1;
        send_frame(8'b1000_1101, 1'b0);
        checks++;
        if ({bus.res_parity, bus.res_pass, bus.in_ready} !== 3'b010) begin
            errors++;
            $display("FAIL pass_result: got par/pass/rdy %b expected 010",
                     {bus.res_parity, bus.res_pass, bus.in_ready});
        end
        @(negedge clk);
        checks++;
        if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL pass_return: got valid %b ready %b expected 0 1", bus.res_valid, bus.in_ready);
        end
        checks++;
        if (frame_cnt !== 4'd1 || err_cnt !== 4'd0) begin
            errors++;
            $display("FAIL pass_cnt: got %0d %0d expected 1 0", frame_cnt, err_cnt);
        end
    endtask

    task automatic test_fail;
        clear_counters();
        send_frame(8'b1000_1101, 1'b1);
        checks++;
        if ({bus.res_parity, bus.res_pass} !== 2'b00) begin
            errors++;
            $display("FAIL fail_result: got par/pass %b expected 00", {bus.res_parity, bus.res_pass});
        end
        @(negedge clk);
        checks++;
        if (frame_cnt !== 4'd1 || err_cnt !== 4'd1) begin
            errors++;
            $display("FAIL fail_cnt: got %0d %0d expected 1 1", frame_cnt, err_cnt);
        end
    endtask

    task automatic test_backpressure;
        clear_counters();
        bus.res_ready = 1'b0;
        send_frame(8'b0000_0111, 1'b1);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_bit   = 1'b1;
            bus.in_exp   = 1'b0;
            @(negedge clk);
            checks++;
            if ({bus.res_valid, bus.in_ready, bus.res_parity, bus.res_pass} !== 4'b1011) begin
                errors++;
                $display("FAIL hold[%0d]: got vld/rdy/par/pass %b expected 1011", i,
                         {bus.res_valid, bus.in_ready, bus.res_parity, bus.res_pass});
            end
        end
        checks++;
        if (frame_cnt !== 4'd0) begin
            errors++;
            $display("FAIL hold_cnt: got %0d expected 0", frame_cnt);
        end
        bus.in_valid  = 1'b0;
        bus.in_bit    = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.res_valid !== 1'b0 || frame_cnt !== 4'd1 || err_cnt !== 4'd0) begin
            errors++;
            $display("FAIL bp_release: got vld %b frame %0d err %0d expected 0 1 0",
                     bus.res_valid, frame_cnt, err_cnt);
        end
        send_frame(8'b1000_1101, 1'b0);
        checks++;
        if ({bus.res_parity, bus.res_pass} !== 2'b01) begin
            errors++;
            $display("FAIL bp_next_frame: got par/pass %b expected 01", {bus.res_parity, bus.res_pass});
        end
        @(negedge clk);
        checks++;
        if (frame_cnt !== 4'd2) begin
            errors++;
            $display("FAIL bp_next_cnt: got %0d expected 2", frame_cnt);
        end
    endtask

    task automatic test_valid_toggle;
        clear_counters();
        bus.res_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_bit   = 1'b1;
            bus.in_exp   = 1'b0;
            @(negedge clk);
            bus.in_valid = 1'b0;
            checks++;
            if (bus.res_valid !== (i == 7)) begin
                errors++;
                $display("FAIL toggle_valid[%0d]: got %b expected %b", i, bus.res_valid, (i == 7));
            end
        end
        bus.in_bit = 1'b0;
        checks++;
        if ({bus.res_parity, bus.res_pass} !== 2'b01) begin
            errors++;
            $display("FAIL toggle_result: got par/pass %b expected 01", {bus.res_parity, bus.res_pass});
        end
        @(negedge clk);
        checks++;
        if (frame_cnt !== 4'd1 || err_cnt !== 4'd0) begin
            errors++;
            $display("FAIL toggle_cnt: got %0d %0d expected 1 0", frame_cnt, err_cnt);
        end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_bit   = 1'b1;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_bit   = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.in_ready, bus.res_valid, bus.res_pass, bus.res_parity} !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_outputs: got %b expected 0000",
                     {bus.in_ready, bus.res_valid, bus.res_pass, bus.res_parity});
        end
        checks++;
        if (frame_cnt !== 4'd0 || err_cnt !== 4'd0) begin
            errors++;
            $display("FAIL midreset_cnt: got %0d %0d expected 0 0", frame_cnt, err_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(8'b1000_1101, 1'b0);
        checks++;
        if ({bus.res_parity, bus.res_pass} !== 2'b01) begin
            errors++;
            $display("FAIL midreset_result: got par/pass %b expected 01", {bus.res_parity, bus.res_pass});
        end
        @(negedge clk);
        checks++;
        if (frame_cnt !== 4'd1 || err_cnt !== 4'd0) begin
            errors++;
            $display("FAIL midreset_after: got %0d %0d expected 1 0", frame_cnt, err_cnt);
        end
    endtask

    task automatic test_saturation;
        clear_counters();
        for (int f = 0; f < 20; f++) begin
            send_frame(8'h00, 1'b1);
            @(negedge clk);
            if (f == 14) begin
                checks++;
                if (frame_cnt !== 4'd15 || err_cnt !== 4'd15) begin
                    errors++;
                    $display("FAIL sat_reach: got %0d %0d expected 15 15", frame_cnt, err_cnt);
                end
            end
        end
        checks++;
        if (frame_cnt !== 4'd15 || err_cnt !== 4'd15) begin
            errors++;
            $display("FAIL sat_hold: got %0d %0d expected 15 15", frame_cnt, err_cnt);
        end
        send_frame(8'h00, 1'b1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if (frame_cnt !== 4'd0 || err_cnt !== 4'd0 || bus.res_valid !== 1'b0) begin
            errors++;
            $display("FAIL clr_vs_inc: got frame %0d err %0d vld %b expected 0 0 0",
                     frame_cnt, err_cnt, bus.res_valid);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        clr           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_bit    = 1'b0;
        bus.in_exp    = 1'b0;
        bus.res_ready = 1'b1;
        test_reset();
        test_pass();
        test_fail();
        test_backpressure();
        test_valid_toggle();
        test_reset_mid();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/parity_frame_checker.md
PARITY_FRAME_CHECKER -- requirements
Module: parity_frame_checker

Interface
REQ-001 Parameter FRAME_LEN, default 8, SHALL set the parity beats per frame; legal range 2..255.
REQ-002 Parameter CNT_W, default 16, SHALL set the frame and error counter width; legal range 4..32.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low; one clock only.
REQ-005 in_valid  input  1  SHALL mark that a parity beat is present.
REQ-006 in_ready  output  1  SHALL indicate the block accepts a beat this cycle.
REQ-007 in_bit  input  1  SHALL carry the per-word parity bit from the upstream 5-input XOR stage.
REQ-008 in_exp  input  1  SHALL carry the expected frame parity; sampled only on the last beat of a frame.
REQ-009 res_valid  output  1  SHALL mark a frame result is present.
REQ-010 res_ready  input  1  SHALL indicate the consumer accepts the result.
REQ-011 res_pass  output  1  SHALL be 1 when computed frame parity equals the sampled in_exp.
REQ-012 res_parity  output  1  SHALL be the XOR of all FRAME_LEN accepted in_bit values of the frame.
REQ-013 frame_cnt  output  CNT_W  SHALL count results handed off.
REQ-014 err_cnt  output  CNT_W  SHALL count handed-off results with res_pass=0.
REQ-015 clr  input  1  SHALL be a synchronous clear of frame_cnt and err_cnt.

Function
REQ-016 The FSM SHALL have two states: ACCUM (in_ready=1, res_valid=0) and RESULT (in_ready=0, res_valid=1).
REQ-017 A beat SHALL be accepted only when in_valid and in_ready are both 1; cycles with in_valid=0 SHALL change nothing.
REQ-018 On each accepted beat, acc SHALL become acc XOR in_bit and beat index SHALL increment.
REQ-019 On the accepted beat with index FRAME_LEN-1: res_parity <= acc XOR in_bit, res_pass <= (acc XOR in_bit) == in_exp, FSM -> RESULT.
REQ-020 res_valid SHALL assert exactly one cycle after the last beat is accepted (latency 1).
REQ-021 In RESULT, res_valid, res_pass and res_parity SHALL hold stable until res_valid and res_ready are both 1.
REQ-022 On the result handshake: FSM -> ACCUM, acc <= 0, beat index <= 0; a new frame MAY start the following cycle.
REQ-023 In RESULT, in_valid beats SHALL be ignored and not buffered.
REQ-024 On the result handshake, frame_cnt SHALL increment; err_cnt SHALL also increment when res_pass=0.
REQ-025 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-026 clr=1 SHALL force both counters to 0 next cycle, overriding a coincident increment.
REQ-027 clr SHALL NOT affect the FSM, acc, beat index or result outputs.

Reset
REQ-028 While rst_n=0: FSM=ACCUM, acc=0, beat index=0, in_ready=0, res_valid=0, res_pass=0, res_parity=0, frame_cnt=0, err_cnt=0.
REQ-029 in_ready SHALL rise on the first clock edge after rst_n deasserts.
REQ-030 Reset mid-frame or in RESULT SHALL discard the partial frame or pending result with no counter update.

Structure
REQ-031 Package parity_chk_pkg SHALL hold the FSM state enum and the FRAME_LEN/CNT_W defaults.
REQ-032 Sub-module sat_counter (CNT_W, inc, clr, saturating) SHALL be instantiated twice, for frame_cnt and err_cnt.

Verification
REQ-033 FRAME_LEN=8, in_bit 1,0,1,1,0,0,0,1, in_exp=0, res_ready=1 -> res_valid 1 cycle after beat 8, res_parity=0, res_pass=1; then frame_cnt=1, err_cnt=0.
REQ-034 Same bits, in_exp=1 -> res_pass=0, res_parity=0; after handshake err_cnt=1, frame_cnt=1.
REQ-035 res_ready=0 for 5 cycles with in_valid=1 -> result stable, in_ready=0, beats ignored; next frame counts from beat 0 after handshake.
REQ-036 in_valid toggling 1,0,1,0... with 8 valid beats of 1 -> only valid beats count; res_parity=0, result after the 8th valid beat.
REQ-037 CNT_W=4, 20 failing frames -> err_cnt=15 and frame_cnt=15 held; clr coincident with a handshake -> both 0 next cycle.
REQ-038 rst_n pulsed low after 3 beats -> all outputs 0; 8 fresh beats then produce a correct result, frame_cnt=1.
